// File: rtl/iq_freelist_ctrl.sv
// Issue-queue free list: a circular buffer of free IQ indices that feeds dispatch lanes.
// Issue lanes return indices to it, and the returned indices are packed in ascending lane order.
module iq_freelist_ctrl #(
    parameter int DEPTH   = 32,
    parameter int INDEX   = 5,
    parameter int ALLOC_W = 4,
    parameter int FREE_W  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush_i,
    input  logic [$clog2(ALLOC_W+1)-1:0]    alloc_cnt_i,
    output logic [ALLOC_W-1:0][INDEX-1:0]   alloc_idx_o,
    output logic                            alloc_ok_o,
    input  logic [FREE_W-1:0]               free_vld_i,
    input  logic [FREE_W-1:0][INDEX-1:0]    free_idx_i,
    output logic [INDEX:0]                  free_cnt_o,
    output logic                            stall_o,
    output logic                            error_o
);

    localparam int CW = INDEX + 2;

    logic [INDEX-1:0] mem [DEPTH];
    logic [INDEX-1:0] head;
    logic [INDEX-1:0] tail;
    logic [INDEX:0]   count;
    logic [CW-1:0]    req;
    logic [CW-1:0]    grant;
    logic [CW-1:0]    pop;
    logic [CW-1:0]    next_cnt;
    logic [INDEX-1:0] waddr [FREE_W];
    logic             overflow;

    assign free_cnt_o = count;
    assign stall_o    = count < (INDEX+1)'(ALLOC_W);
    assign req        = CW'(alloc_cnt_i);
    assign alloc_ok_o = !flush_i && (req <= CW'(count));
    assign grant      = alloc_ok_o ? req : '0;

    // Offered indices come from pre-edge storage, so entries freed this cycle are not visible yet
    always_comb begin
        for (int unsigned k = 0; k < ALLOC_W; k++) begin
            alloc_idx_o[k] = mem[head + INDEX'(k)];
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < FREE_W; i++) begin
            waddr[i] = tail + pop[INDEX-1:0];
            pop      = pop + CW'(free_vld_i[i]);
        end
    end

    assign next_cnt = CW'(count) - grant + pop;
    assign overflow = next_cnt > CW'(DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= (INDEX+1)'(DEPTH);
            error_o <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= INDEX'(i);
            end
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= (INDEX+1)'(DEPTH);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= INDEX'(i);
            end
        end else begin
            head <= head + INDEX'(grant);
            if (overflow) begin
                count   <= count - (INDEX+1)'(grant);
                error_o <= 1'b1;
            end else begin
                count <= next_cnt[INDEX:0];
                tail  <= tail + INDEX'(pop);
                for (int unsigned i = 0; i < FREE_W; i++) begin
                    if (free_vld_i[i]) begin
                        mem[waddr[i]] <= free_idx_i[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_freelist_ctrl.sv
// Directed bench for iq_freelist_ctrl: a queue model of the free list is checked every cycle,
// and literal checks pin the documented scenarios.
module tb_iq_freelist_ctrl;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 flush = 1'b0;
    logic [2:0]           alloc_cnt = '0;
    logic [3:0]           free_vld = '0;
    logic [3:0][4:0]      free_idx = '0;
    logic [3:0][4:0]      alloc_idx;
    logic                 alloc_ok;
    logic [5:0]           free_cnt;
    logic                 stall;
    logic                 error;

    iq_freelist_ctrl #(.DEPTH(32), .INDEX(5), .ALLOC_W(4), .FREE_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .flush_i(flush),
        .alloc_cnt_i(alloc_cnt),
        .alloc_idx_o(alloc_idx),
        .alloc_ok_o(alloc_ok),
        .free_vld_i(free_vld),
        .free_idx_i(free_idx),
        .free_cnt_o(free_cnt),
        .stall_o(stall),
        .error_o(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an ordered list of free indices plus a sticky error bit
    int q[$];
    bit m_err;
    int g;
    int p;

    function automatic void m_init();
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(i);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_init();
            m_err = 1'b0;
        end else if (flush) begin
            m_init();
        end else begin
            g = (int'(alloc_cnt) <= q.size()) ? int'(alloc_cnt) : 0;
            p = $countones(free_vld);
            for (int k = 0; k < g; k++) void'(q.pop_front());
            if (q.size() + p > 32) begin
                m_err = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) if (free_vld[k]) q.push_back(int'(free_idx[k]));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("alloc_ok", int'(alloc_ok), int'(!flush && int'(alloc_cnt) <= q.size()));
            chk("free_cnt", int'(free_cnt), q.size());
            chk("stall", int'(stall), int'(q.size() < 4));
            chk("error", int'(error), int'(m_err));
            for (int k = 0; k < 4; k++) begin
                if (k < q.size()) chk($sformatf("alloc_idx%0d", k), int'(alloc_idx[k]), q[k]);
            end
        end
    end

    task automatic drive(input int ac, input logic [3:0] fv, input logic [3:0][4:0] fi, input logic fl);
        alloc_cnt = 3'(ac);
        free_vld  = fv;
        free_idx  = fi;
        flush     = fl;
    endtask

    task automatic cyc(input int ac, input logic [3:0] fv, input logic [3:0][4:0] fi, input logic fl);
        @(posedge clk);
        #1;
        drive(ac, fv, fi, fl);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0][4:0] fi;
        #1 reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_cnt", int'(free_cnt), 32);
        chk("rst_stall", int'(stall), 0);
        chk("rst_idx", int'(alloc_idx), int'({5'd3, 5'd2, 5'd1, 5'd0}));
        chk("rst_err", int'(error), 0);
        #2 reset = 1'b0;

        cyc(4, 4'b0000, '0, 1'b0);
        chk("a4_ok", int'(alloc_ok), 1);
        chk("a4_idx", int'(alloc_idx), int'({5'd3, 5'd2, 5'd1, 5'd0}));
        cyc(0, 4'b0000, '0, 1'b0);
        chk("a4_next_idx", int'(alloc_idx), int'({5'd7, 5'd6, 5'd5, 5'd4}));
        chk("a4_next_cnt", int'(free_cnt), 28);

        repeat (6) cyc(4, 4'b0000, '0, 1'b0);
        cyc(2, 4'b0000, '0, 1'b0);
        cyc(3, 4'b0000, '0, 1'b0);
        chk("short_ok", int'(alloc_ok), 0);
        chk("short_cnt", int'(free_cnt), 2);
        chk("short_stall", int'(stall), 1);
        cyc(0, 4'b0000, '0, 1'b0);
        chk("short_hold", int'(free_cnt), 2);
        cyc(2, 4'b0000, '0, 1'b0);
        chk("exact_ok", int'(alloc_ok), 1);
        cyc(0, 4'b0000, '0, 1'b0);
        chk("empty_cnt", int'(free_cnt), 0);

        cyc(0, 4'b1010, {5'd17, 5'd0, 5'd9, 5'd0}, 1'b0);
        cyc(0, 4'b0000, '0, 1'b0);
        chk("compact_cnt", int'(free_cnt), 2);
        chk("compact_l0", int'(alloc_idx[0]), 9);
        chk("compact_l1", int'(alloc_idx[1]), 17);

        cyc(1, 4'b0000, '0, 1'b0);
        cyc(2, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);
        chk("rbw_ok", int'(alloc_ok), 0);
        cyc(0, 4'b0000, '0, 1'b0);
        chk("rbw_cnt", int'(free_cnt), 5);
        chk("rbw_idx", int'(alloc_idx), int'({5'd3, 5'd2, 5'd1, 5'd17}));

        cyc(0, 4'b0000, '0, 1'b1);
        cyc(1, 4'b0000, '0, 1'b0);
        cyc(0, 4'b0011, {5'd0, 5'd0, 5'd5, 5'd0}, 1'b0);
        cyc(0, 4'b0000, '0, 1'b0);
        chk("ovf_err", int'(error), 1);
        chk("ovf_cnt", int'(free_cnt), 31);
        chk("ovf_idx", int'(alloc_idx), int'({5'd4, 5'd3, 5'd2, 5'd1}));
        cyc(0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0);
        repeat (8) cyc(4, 4'b0000, '0, 1'b0);
        chk("ovf_tail_idx", int'(alloc_idx), int'({5'd0, 5'd31, 5'd30, 5'd29}));
        cyc(0, 4'b0000, '0, 1'b1);
        cyc(0, 4'b0000, '0, 1'b0);
        chk("flush_err_hold", int'(error), 1);
        chk("flush_cnt", int'(free_cnt), 32);

        @(posedge clk);
        #1 drive(4, 4'b1111, {5'd3, 5'd2, 5'd1, 5'd0}, 1'b0);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("midrst_err", int'(error), 0);
        chk("midrst_cnt", int'(free_cnt), 32);
        chk("midrst_idx", int'(alloc_idx), int'({5'd3, 5'd2, 5'd1, 5'd0}));
        #2;
        drive(0, 4'b0000, '0, 1'b0);
        reset = 1'b0;

        for (int c = 0; c < 40; c++) begin
            for (int k = 0; k < 4; k++) fi[k] = 5'((4 * c + k) % 32);
            cyc(4, 4'b1111, fi, 1'b0);
        end
        chk("wrap_cnt", int'(free_cnt), 32);
        cyc(4, 4'b1111, {5'd9, 5'd8, 5'd7, 5'd6}, 1'b1);
        chk("flush_ok", int'(alloc_ok), 0);
        cyc(0, 4'b0000, '0, 1'b0);
        chk("flush2_cnt", int'(free_cnt), 32);
        chk("flush2_idx", int'(alloc_idx), int'({5'd3, 5'd2, 5'd1, 5'd0}));

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iq_freelist_ctrl.md
IQ_FREELIST_CTRL -- requirements
Module: iq_freelist_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of IQ entries, power of 2.
REQ-002 SHALL have parameter INDEX, default 5: log2(DEPTH), the IQ index width.
REQ-003 SHALL have parameter ALLOC_W, default 4: allocation (dispatch) lanes.
REQ-004 SHALL have parameter FREE_W, default 4: free (issue) lanes.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port flush_i, input, 1: recover all IQ entries to free.
REQ-008 SHALL have port alloc_cnt_i, input, $clog2(ALLOC_W+1): number of entries requested this cycle.
REQ-009 SHALL have port alloc_idx_o, output, ALLOC_W x INDEX: free indices offered, lane k = storage[head+k].
REQ-010 SHALL have port alloc_ok_o, output, 1: request granted this cycle.
REQ-011 SHALL have port free_vld_i, input, FREE_W: per-lane free valid.
REQ-012 SHALL have port free_idx_i, input, FREE_W x INDEX: per-lane IQ index being returned.
REQ-013 SHALL have port free_cnt_o, output, INDEX+1: current number of free entries.
REQ-014 SHALL have port stall_o, output, 1: free_cnt_o < ALLOC_W.
REQ-015 SHALL have port error_o, output, 1: sticky overflow flag.

Function
REQ-016 SHALL hold a DEPTH x INDEX circular storage plus head pointer, tail pointer and count; pointers wrap modulo DEPTH.
REQ-017 SHALL drive alloc_idx_o, alloc_ok_o and stall_o combinationally from current-cycle state and inputs (zero read latency).
REQ-018 SHALL assert alloc_ok_o iff alloc_cnt_i <= free_cnt_o and flush_i=0; alloc_cnt_i=0 gives alloc_ok_o=1 with no state change.
REQ-019 SHALL, when alloc_ok_o=1, advance head by alloc_cnt_i; on grant failure head and count are unchanged (all-or-nothing).
REQ-020 SHALL compact valid free lanes in ascending lane order: the j-th set bit of free_vld_i is written to storage[tail+j]; tail advances by popcount(free_vld_i).
REQ-021 SHALL update count = count - granted_alloc + popcount(free_vld_i) each cycle.
REQ-022 SHALL NOT expose same-cycle freed entries to allocation: reads use pre-edge storage and count (read-before-write).
REQ-023 SHALL detect overflow when count - granted_alloc + popcount(free_vld_i) > DEPTH; that cycle all free writes are dropped, tail does not move, allocation proceeds normally, error_o sets and stays 1 until reset.
REQ-024 SHALL give flush_i priority over alloc and free: next edge head=0, tail=0, count=DEPTH, storage[i]=i for all i; error_o unchanged.
REQ-025 SHALL represent full as count=DEPTH with head==tail; head==tail with count=0 is empty; no pointer-only full/empty decode.
REQ-026 SHALL keep alloc_idx_o lanes k >= free_cnt_o at whatever storage holds (don't-care); consumers gate on alloc_ok_o.
REQ-027 SHALL not check free_idx_i for duplicates or already-free indices; only the count overflow of REQ-023 is detected.

Reset
REQ-028 SHALL, on reset assertion, asynchronously set head=0, tail=0, count=DEPTH, storage[i]=i, error_o=0.
REQ-029 SHALL therefore present free_cnt_o=DEPTH, stall_o=0, alloc_idx_o={3,2,1,0} (lanes 3..0) during and after reset.
REQ-030 SHALL abandon any in-flight alloc/free when reset asserts mid-cycle; no partial update survives.

Verification
REQ-031 SHALL cover: reset, alloc_cnt_i=4 for one cycle -> alloc_idx_o={3,2,1,0}, alloc_ok_o=1; next cycle alloc_idx_o={7,6,5,4}, free_cnt_o=28.
REQ-032 SHALL cover: drain to free_cnt_o=2, alloc_cnt_i=3 -> alloc_ok_o=0, free_cnt_o stays 2, stall_o=1; alloc_cnt_i=2 -> alloc_ok_o=1, free_cnt_o=0.
REQ-033 SHALL cover: free_cnt_o=0, free_vld_i=4'b1010 with idx lane1=9, lane3=17 -> next cycle free_cnt_o=2, alloc_idx_o lane0=9, lane1=17.
REQ-034 SHALL cover: free_cnt_o=1, same cycle alloc_cnt_i=2 and 4 valid frees -> alloc_ok_o=0, next free_cnt_o=5.
REQ-035 SHALL cover: free_cnt_o=31, 2 valid frees, no alloc -> error_o=1, free_cnt_o stays 31, tail unchanged; error_o holds through flush and clears only on reset.
REQ-036 SHALL cover: 40 cycles of alloc 4/free 4 (wrap) then flush_i with concurrent alloc/free -> alloc_ok_o=0, next free_cnt_o=32, alloc_idx_o={3,2,1,0}.
